// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store unit: geometry, FSM encoding, op codes.
package dmem_pkg;

  localparam int DMEM_AW = 6;
  localparam int DMEM_DW = 16;
  localparam int DMEM_LW = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_RCAP = 3'd3,
    ST_RSP  = 3'd4
  } lsu_state_e;

  localparam logic LSU_OP_LOAD  = 1'b0;
  localparam logic LSU_OP_STORE = 1'b1;

endpackage

// File: rtl/dmem_lsu.sv
// Load/store initiator for the 64x16 data memory: sequences burst fills and loads one word per
// access and hides the memory's registered-read latency behind a backpressured response stream.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int AW = DMEM_AW,
  parameter int DW = DMEM_DW,
  parameter int LW = DMEM_LW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [LW-1:0] req_len,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic          wr_done,
  output logic          busy,
  output logic          mem_wr_en,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  lsu_state_e    r_state;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_cnt;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rsp_data;
  logic          r_rsp_last;
  logic          r_wr_done;

  logic          w_accept;
  logic          w_cnt_zero;
  logic          w_in_wr;
  logic          w_in_rd;

  assign w_accept   = req_valid && (r_state == ST_IDLE);
  assign w_cnt_zero = (r_cnt == {LW{1'b0}});
  assign w_in_wr    = (r_state == ST_WR);
  assign w_in_rd    = (r_state == ST_RD);

  // Burst sequencer: address/count tracking, read capture and the wr_done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= {AW{1'b0}};
      r_cnt      <= {LW{1'b0}};
      r_wdata    <= {DW{1'b0}};
      r_rsp_data <= {DW{1'b0}};
      r_rsp_last <= 1'b0;
      r_wr_done  <= 1'b0;
    end else begin
      r_wr_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr  <= req_addr;
            r_cnt   <= req_len;
            r_wdata <= req_wdata;
            r_state <= (req_we == LSU_OP_STORE) ? ST_WR : ST_RD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WR: begin
          if (w_cnt_zero) begin
            r_state   <= ST_IDLE;
            r_wr_done <= 1'b1;
          end else begin
            r_addr <= r_addr + AW'(1);
            r_cnt  <= r_cnt - LW'(1);
          end
        end
        ST_RD: begin
          r_state <= ST_RCAP;
        end
        // Memory data is valid here, one cycle after the read strobe.
        ST_RCAP: begin
          r_rsp_data <= mem_rdata;
          r_rsp_last <= w_cnt_zero;
          r_state    <= ST_RSP;
        end
        ST_RSP: begin
          if (rsp_ready) begin
            if (w_cnt_zero) begin
              r_state <= ST_IDLE;
            end else begin
              r_addr  <= r_addr + AW'(1);
              r_cnt   <= r_cnt - LW'(1);
              r_state <= ST_RD;
            end
          end else begin
            r_state <= ST_RSP;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory port decoded from registered state only, so it collapses immediately on reset.
  assign mem_wr_en = w_in_wr;
  assign mem_rd_en = w_in_rd;
  assign mem_addr  = (w_in_wr || w_in_rd) ? r_addr : {AW{1'b0}};
  assign mem_wdata = w_in_wr ? r_wdata : {DW{1'b0}};

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign rsp_valid = (r_state == ST_RSP);
  assign rsp_data  = r_rsp_data;
  assign rsp_last  = r_rsp_last;
  assign wr_done   = r_wr_done;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu with a registered-read 64x16 memory model.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [5:0]  req_addr = 6'd0;
  logic [2:0]  req_len = 3'd0;
  logic [15:0] req_wdata = 16'h0000;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic        rsp_last;
  logic        wr_done;
  logic        busy;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [5:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;

  logic [15:0] mem [0:63] = '{default: 16'h0000};

  typedef struct packed { logic [15:0] d; logic l; } rsp_t;
  typedef struct packed { logic [5:0] a; logic [15:0] d; } wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int wr_done_cnt = 0;

  dmem_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .wr_done(wr_done), .busy(busy),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_req(input logic we, input logic [5:0] a, input logic [2:0] len,
                          input logic [15:0] d);
    int n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_len = len; req_wdata = d;
    @(negedge clk);
    while (!req_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_store(input logic [5:0] a, input logic [2:0] len, input logic [15:0] d);
    int c = 0;
    for (int i = 0; i <= int'(len); i++) begin
      logic [5:0] wa;
      wa = a + 6'(i);
      wr_q.push_back('{a: wa, d: d});
    end
    send_req(1'b1, a, len, d);
    do begin
      @(negedge clk);
      c++;
    end while (!wr_done && c < 40);
    chk("wr_done_latency", c, int'(len) + 2);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || rsp_q.size() != 0) && n < 200);
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_load(input logic [5:0] a, input logic [2:0] len);
    int c = 0;
    send_req(1'b0, a, len, 16'h0000);
    do begin
      @(negedge clk);
      c++;
    end while (!rsp_valid && c < 20);
    chk("load_latency", c, 3);
  endtask

  initial begin
    // T1: reset values while rst is held
    #3;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_last", {31'd0, rsp_last}, 32'd0);
    chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    chk("rst_wr_done", {31'd0, wr_done}, 32'd0);
    chk("rst_mem_en", {30'd0, mem_wr_en, mem_rd_en}, 32'd0);
    chk("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (mem_wr_en && mem_rd_en) chk("wr_rd_exclusive", 32'd1, 32'd0);
        if (mem_rd_en) rd_cnt++;
        if (wr_done) wr_done_cnt++;
        if (mem_wr_en) begin
          if (wr_q.size() == 0) begin
            chk("unexpected_write_addr", {26'd0, mem_addr}, 32'hFFFF_FFFF);
          end else begin
            wr_t w;
            w = wr_q.pop_front();
            chk("write_addr", {26'd0, mem_addr}, {26'd0, w.a});
            chk("write_data", {16'd0, mem_wdata}, {16'd0, w.d});
          end
        end
        if (rsp_valid && rsp_ready) begin
          if (rsp_q.size() == 0) begin
            chk("unexpected_rsp", {16'd0, rsp_data}, 32'hFFFF_FFFF);
          end else begin
            rsp_t r;
            r = rsp_q.pop_front();
            chk("rsp_data", {16'd0, rsp_data}, {16'd0, r.d});
            chk("rsp_last", {31'd0, rsp_last}, {31'd0, r.l});
          end
        end
      end
    join_none

    // T2: single store then single load
    do_store(6'd5, 3'd0, 16'hBEEF);
    rsp_q.push_back('{d: 16'hBEEF, l: 1'b1});
    do_load(6'd5, 3'd0);
    wait_idle();

    // T3: fill wrapping past address 63
    do_store(6'd62, 3'd3, 16'h1234);
    for (int i = 0; i < 4; i++) rsp_q.push_back('{d: 16'h1234, l: (i == 3)});
    do_load(6'd62, 3'd3);
    wait_idle();

    // T4: backpressure on a two-word load
    do_store(6'd0, 3'd0, 16'hAAAA);
    do_store(6'd1, 3'd0, 16'h5555);
    rsp_q.push_back('{d: 16'hAAAA, l: 1'b0});
    rsp_q.push_back('{d: 16'h5555, l: 1'b1});
    rsp_ready = 1'b0;
    begin
      int rd_before;
      rd_before = rd_cnt;
      do_load(6'd0, 3'd1);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
        chk("bp_data_stable", {16'd0, rsp_data}, 32'h0000_AAAA);
        chk("bp_no_reread", {31'd0, mem_rd_en}, 32'd0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      wait_idle();
      chk("bp_read_count", rd_cnt - rd_before, 32'd2);
    end

    // T5: request held while an 8-word fill is in progress
    for (int i = 0; i < 8; i++) wr_q.push_back('{a: 6'd20 + 6'(i), d: 16'h0F0F});
    send_req(1'b1, 6'd20, 3'd7, 16'h0F0F);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd20; req_len = 3'd0;
    rsp_q.push_back('{d: 16'h0F0F, l: 1'b1});
    begin
      int n = 0;
      @(negedge clk);
      while (busy && n < 20) begin
        chk("busy_not_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        n++;
      end
      chk("busy_cycles", n, 8);
      chk("first_idle_ready", {31'd0, req_ready}, 32'd1);
      chk("first_idle_wr_done", {31'd0, wr_done}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("held_req_taken", {31'd0, mem_rd_en}, 32'd1);
      wait_idle();
    end

    // T6: asynchronous reset in the middle of a fill
    for (int i = 0; i < 3; i++) wr_q.push_back('{a: 6'd10 + 6'(i), d: 16'h7777});
    send_req(1'b1, 6'd10, 3'd7, 16'h7777);
    begin
      int n = 0;
      int w = 0;
      while (w < 3 && n < 20) begin
        @(negedge clk);
        if (mem_wr_en) w++;
        n++;
      end
      chk("pre_rst_writes", w, 3);
      @(posedge clk); #2;
      chk("pre_rst_wr_en", {31'd0, mem_wr_en}, 32'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
      chk("async_rst_busy", {31'd0, busy}, 32'd0);
      chk("async_rst_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
    end
    rsp_q.push_back('{d: 16'h7777, l: 1'b0});
    rsp_q.push_back('{d: 16'h0000, l: 1'b1});
    do_load(6'd12, 3'd1);
    wait_idle();

    chk("wr_done_pulses", wr_done_cnt, 5);
    chk("write_queue_drained", wr_q.size(), 0);
    chk("rsp_queue_drained", rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
